frame_scanout: RTL and testbench
================================

Name: frame_scanout

Overview:
- Pixel source feeding the VGA driver's x/y → red/green/blue interface.
- Scans a double-buffered 160x120, 4-bit-indexed framebuffer; each framebuffer pixel is scaled 4x4 onto the 640x480 display.
- Indices pass through a 16-entry 12-bit palette.
- Exactly 2-cycle x/y-to-colour latency, matching the driver's pix_dly=2.
- Game logic writes the back buffer and requests a buffer swap, which takes effect only at the frame start.

Parameters:
FB_W, 160, framebuffer width in pixels
FB_H, 120, framebuffer height in pixels
SCALE_SHIFT, 2, log2 of display pixels per framebuffer pixel, per axis
IDX_W, 4, palette index width
AW, 15, per-bank framebuffer address width (FB_W*FB_H must be ≤ 2^AW)

Ports:
dclk  in  1  pixel clock
clr  in  1  asynchronous active-high reset
x  in  10  display column from driver, 0..639
y  in  10  display row from driver, 0..479
pre_frame  in  1  one-cycle frame-start strobe from driver
red  out  4  pixel red
green  out  4  pixel green
blue  out  4  pixel blue
wr_en  in  1  framebuffer write strobe
wr_addr  in  AW  back-buffer address, computed as row*FB_W+col
wr_data  in  IDX_W  palette index to store
swap_req  in  1  level; request front/back exchange
swap_ack  out  1  one-cycle pulse when swap performed
front_sel  out  1  bank currently displayed
pal_we  in  1  palette write strobe
pal_idx  in  IDX_W  palette entry to write
pal_rgb  in  12  {r,g,b}, 4 bits each

Behaviour:
- Reset: clr is asynchronous, active-high; dclk is the clock.
- Reset values: front_sel=0, swap_ack=0, stage registers=0, all palette entries=12'h000. The rgb outputs therefore read 0 during and after reset. RAM contents are not reset.
- Stage 1, edge N:
  - fx = x>>SCALE_SHIFT; fy = y>>SCALE_SHIFT.
  - addr_q <= fy*160 + fx, implemented as (fy<<7)+(fy<<5)+fx, 15-bit result.
  - bank_q <= front_sel.
  - oor_q <= (x≥640 || y≥480).
- Stage 2, edge N+1:
  - idx_q <= ram[{bank_q,addr_q}].
  - oor2_q <= oor_q.
- Output: {red,green,blue} = oor2_q ? 0 : palette[idx_q].
  - This output is combinational from registers.
  - It must be stable before edge N+2, so the driver samples the x,y presented at edge N exactly 2 cycles later.
- No bubbles: the pipeline accepts new x,y every cycle.
- Framebuffer write:
  - On edge with wr_en=1 and wr_addr < FB_W*FB_H: ram[{~front_sel,wr_addr}] <= wr_data.
  - wr_addr ≥ 19200 is ignored.
  - Writes never touch the front bank.
- Swap:
  - On edge with pre_frame=1 and swap_req=1: front_sel toggles and swap_ack=1 for exactly that following cycle. Otherwise swap_ack=0.
  - swap_req held high across several frames swaps once per frame. The requester must deassert swap_req after swap_ack.
- Write coincident with swap edge: uses the pre-toggle front_sel, so it lands in the bank that is about to be displayed. Game logic must not write in the swap_ack cycle window; this is documented, not guarded.
- Swap timing: pre_frame occurs in vertical blanking, and bank_q is sampled per pixel. The swap therefore never tears the visible image.
- Palette write: on edge with pal_we=1, palette[pal_idx] <= pal_rgb. The new value is visible on the output from the next cycle; there is no bypass.
- Simultaneous pal_we and scanout of the same entry: the read shows the old value in that cycle.
- Reset mid-frame:
  - Outputs go to 0 asynchronously and front_sel returns to 0.
  - Scanout resumes with the next x,y after clr falls.

Decomposition:
- Shared package (game-wide): FB_W, FB_H, SCALE_SHIFT, IDX_W, AW, FB_PIXELS=19200, and the 12-bit colour {r,g,b} field layout.
- One sub-module: fb_ram, a simple dual-port synchronous RAM.
  - Size: 2^(AW+1) x IDX_W.
  - One write port and one registered read port, same clock, no reset, inferred as block RAM.
  - Read-during-write to the same address returns don't-care; this cannot occur because the read and write target different banks.

Test Plan:
- Palette/pixel readback: write pal[3]=12'hF80; write back-bank addr 0 = 3; pulse swap_req with pre_frame → swap_ack=1 for 1 cycle, front_sel=1. Then x=0,y=0 → red=F, green=8, blue=0 exactly 2 edges later.
- 4x4 scaling: back pixel (fx=5,fy=2), i.e. addr 325, = index 7. After swap, x=20..23 with y=8..11 all show pal[7]; x=24 shows addr 326's colour.
- Back-buffer isolation: with front_sel=0, write addr 100 = 9 while scanning it → display unchanged until the next swap; then it shows pal[9].
- Out-of-range: wr_addr=19200 and 32767 with wr_en → no RAM change. x=700 → rgb=0 two cycles later.
- Swap gating: swap_req=1 with no pre_frame for 1000 cycles → no toggle. Next pre_frame → single toggle. swap_req held for 3 frames → 3 toggles and 3 ack pulses.
- Reset mid-stream: assert clr during active scan → rgb=0, front_sel=0, swap_ack=0, palette all 0 immediately. After release, a new palette write appears on the output after the 2-cycle pipeline latency.

Source files
------------

// File: rtl/frame_scanout_pkg.sv
// Shared game-wide constants and the 12-bit colour layout used by the scanout path.
package frame_scanout_pkg;

    localparam int FB_W        = 160;
    localparam int FB_H        = 120;
    localparam int SCALE_SHIFT = 2;
    localparam int IDX_W       = 4;
    localparam int AW          = 15;
    localparam int FB_PIXELS   = FB_W * FB_H;
    localparam int PAL_N       = 1 << IDX_W;
    localparam int FX_W        = 10 - SCALE_SHIFT;
    localparam int DISP_W      = 640;
    localparam int DISP_H      = 480;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // Row-major framebuffer address; fy*160 built from two shifts so no multiplier is needed.
    function automatic logic [AW-1:0] fb_addr(input logic [FX_W-1:0] fy, input logic [FX_W-1:0] fx);
        logic [AW-1:0] fy_w;
        logic [AW-1:0] fx_w;
        fy_w = {{(AW-FX_W){1'b0}}, fy};
        fx_w = {{(AW-FX_W){1'b0}}, fx};
        return (fy_w << 7) + (fy_w << 5) + fx_w;
    endfunction

endpackage

// File: rtl/frame_scanout_fb_ram.sv
// Simple dual-port synchronous RAM holding both framebuffer banks; registered read, no reset.
module fb_ram #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // Write port and registered read port share the pixel clock.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/frame_scanout.sv
// Two-stage x/y-to-colour pipeline over a double-buffered, 4x-scaled, palette-indexed framebuffer.
module frame_scanout
    import frame_scanout_pkg::*;
(
    input  logic             dclk,
    input  logic             clr,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic             pre_frame,
    output logic [3:0]       red,
    output logic [3:0]       green,
    output logic [3:0]       blue,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [IDX_W-1:0] wr_data,
    input  logic             swap_req,
    output logic             swap_ack,
    output logic             front_sel,
    input  logic             pal_we,
    input  logic [IDX_W-1:0] pal_idx,
    input  logic [11:0]      pal_rgb
);

    logic [AW-1:0]    addr_d, addr_q;
    logic             bank_d, bank_q;
    logic             oor_d, oor_q;
    logic             oor2_d, oor2_q;
    logic             front_sel_d, front_sel_q;
    logic             swap_ack_d, swap_ack_q;
    rgb_t             pal_d [PAL_N];
    rgb_t             pal_q [PAL_N];

    logic             ram_we;
    logic [AW:0]      ram_waddr;
    logic [AW:0]      ram_raddr;
    logic [IDX_W-1:0] idx_q;
    logic             swap_now;
    rgb_t             pix;

    // Next-state for the address stage, bank select, swap handshake and palette.
    always_comb begin
        addr_d      = fb_addr(y[9:SCALE_SHIFT], x[9:SCALE_SHIFT]);
        bank_d      = front_sel_q;
        oor_d       = (x >= 10'd640) || (y >= 10'd480);
        oor2_d      = oor_q;
        swap_now    = pre_frame & swap_req;
        front_sel_d = front_sel_q ^ swap_now;
        swap_ack_d  = swap_now;
        pal_d       = pal_q;
        if (pal_we) begin
            pal_d[pal_idx] = rgb_t'(pal_rgb);
        end else begin
            pal_d = pal_q;
        end
    end

    // Writes always target the back bank, judged by front_sel before any toggle on this edge.
    always_comb begin
        ram_we    = wr_en && (wr_addr < AW'(FB_PIXELS));
        ram_waddr = {~front_sel_q, wr_addr};
        ram_raddr = {bank_q, addr_q};
    end

    // Pipeline, swap and palette registers with asynchronous clear.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            addr_q      <= {AW{1'b0}};
            bank_q      <= 1'b0;
            oor_q       <= 1'b0;
            oor2_q      <= 1'b0;
            front_sel_q <= 1'b0;
            swap_ack_q  <= 1'b0;
            for (int i = 0; i < PAL_N; i++) begin
                pal_q[i] <= rgb_t'(12'h000);
            end
        end else begin
            addr_q      <= addr_d;
            bank_q      <= bank_d;
            oor_q       <= oor_d;
            oor2_q      <= oor2_d;
            front_sel_q <= front_sel_d;
            swap_ack_q  <= swap_ack_d;
            pal_q       <= pal_d;
        end
    end

    // The RAM's registered read port is the second pipeline stage.
    fb_ram #(
        .ADDR_W (AW + 1),
        .DATA_W (IDX_W)
    ) u_fb_ram (
        .clk   (dclk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (wr_data),
        .raddr (ram_raddr),
        .rdata (idx_q)
    );

    // Palette is fully cleared on reset, so an unreset RAM index still yields black.
    always_comb begin
        if (oor2_q) begin
            pix = rgb_t'(12'h000);
        end else begin
            pix = pal_q[idx_q];
        end
    end

    assign red       = pix.r;
    assign green     = pix.g;
    assign blue      = pix.b;
    assign swap_ack  = swap_ack_q;
    assign front_sel = front_sel_q;

endmodule

// File: tb/tb_frame_scanout.sv
// Randomised and directed bench for frame_scanout against a behavioural pixel/bank/palette model.
module tb_frame_scanout;

    localparam int NPIX = 19200;

    logic        dclk = 1'b0;
    logic        clr  = 1'b1;
    logic [9:0]  x = 10'd0, y = 10'd0;
    logic        pre_frame = 1'b0;
    logic [3:0]  red, green, blue;
    logic        wr_en = 1'b0;
    logic [14:0] wr_addr = 15'd0;
    logic [3:0]  wr_data = 4'd0;
    logic        swap_req = 1'b0;
    logic        swap_ack, front_sel;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_idx = 4'd0;
    logic [11:0] pal_rgb = 12'h000;

    int n_checks = 0;
    int n_fail   = 0;

    frame_scanout dut (
        .dclk(dclk), .clr(clr), .x(x), .y(y), .pre_frame(pre_frame),
        .red(red), .green(green), .blue(blue),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .swap_req(swap_req), .swap_ack(swap_ack), .front_sel(front_sel),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb)
    );

    always #5 dclk = ~dclk;

    // ---------------- behavioural model ----------------
    logic [3:0]  ram_m   [2][NPIX];
    bit          known_m [2][NPIX];
    logic [11:0] pal_m   [16];
    logic        front_m = 1'b0, ack_m = 1'b0;
    logic        p1_bank = 1'b0, p1_oor = 1'b0;
    int          p1_addr = 0;
    logic        s2_ok = 1'b0, s2_zero = 1'b1;
    logic [3:0]  s2_idx = 4'd0;

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < NPIX; a++) known_m[b][a] = 1'b0;
        for (int i = 0; i < 16; i++) pal_m[i] = 12'h000;
    end

    always @(posedge dclk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) pal_m[i] <= 12'h000;
            front_m <= 1'b0; ack_m <= 1'b0;
            p1_bank <= 1'b0; p1_addr <= 0; p1_oor <= 1'b0;
            s2_ok <= 1'b1; s2_zero <= 1'b1;
        end else begin
            s2_ok   <= p1_oor || known_m[p1_bank][p1_addr];
            s2_zero <= p1_oor;
            s2_idx  <= ram_m[p1_bank][p1_addr];
            p1_oor  <= (x >= 10'd640) || (y >= 10'd480);
            p1_addr <= ((x >= 10'd640) || (y >= 10'd480)) ? 0 : (int'(y) / 4) * 160 + int'(x) / 4;
            p1_bank <= front_m;
            if (wr_en && int'(wr_addr) < NPIX) begin
                ram_m[!front_m][wr_addr]   <= wr_data;
                known_m[!front_m][wr_addr] <= 1'b1;
            end
            if (pal_we) pal_m[pal_idx] <= pal_rgb;
            ack_m <= pre_frame && swap_req;
            if (pre_frame && swap_req) front_m <= !front_m;
        end
    end

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge dclk) begin
        if (s2_ok) chk("rgb_model", {red, green, blue}, s2_zero ? 12'h000 : pal_m[s2_idx]);
        chk("front_sel_model", 12'(front_sel), 12'(front_m));
        chk("swap_ack_model", 12'(swap_ack), 12'(ack_m));
    end

    // ---------------- stimulus helpers ----------------
    task automatic fb_wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = 15'(a); wr_data = 4'(d);
        @(negedge dclk);
        wr_en = 1'b0;
    endtask

    task automatic pal_wr(input int i, input logic [11:0] c);
        pal_we = 1'b1; pal_idx = 4'(i); pal_rgb = c;
        @(negedge dclk);
        pal_we = 1'b0;
    endtask

    task automatic do_swap();
        pre_frame = 1'b1; swap_req = 1'b1;
        @(negedge dclk);
        pre_frame = 1'b0; swap_req = 1'b0;
        @(negedge dclk);
    endtask

    task automatic pix(input int px, input int py, input logic [11:0] exp, input string name);
        x = 10'(px); y = 10'(py);
        @(negedge dclk);
        @(negedge dclk);
        chk(name, {red, green, blue}, exp);
    endtask

    int  acks;
    logic f0;
    logic prev_swap;

    initial begin
        // reset state
        repeat (3) @(negedge dclk);
        chk("reset_rgb", {red, green, blue}, 12'h000);
        chk("reset_front", 12'(front_sel), 12'h000);
        chk("reset_ack", 12'(swap_ack), 12'h000);
        clr = 1'b0;
        @(negedge dclk);

        // palette / pixel readback
        pal_wr(3, 12'hF80);
        fb_wr(0, 3);
        pre_frame = 1'b1; swap_req = 1'b1;
        @(negedge dclk);
        pre_frame = 1'b0; swap_req = 1'b0;
        chk("swap_ack_pulse", 12'(swap_ack), 12'h001);
        chk("front_after_swap", 12'(front_sel), 12'h001);
        @(negedge dclk);
        chk("swap_ack_single", 12'(swap_ack), 12'h000);
        x = 10'd0; y = 10'd0;
        @(negedge dclk);
        @(negedge dclk);
        chk("red_F", 12'(red), 12'h00F);
        chk("green_8", 12'(green), 12'h008);
        chk("blue_0", 12'(blue), 12'h000);

        // 4x4 scaling around addr 325 (fx=5, fy=2)
        pal_wr(7, 12'h1A7);
        pal_wr(6, 12'h0C3);
        fb_wr(325, 7);
        fb_wr(326, 6);
        do_swap();
        for (int yy = 8; yy < 12; yy++)
            for (int xx = 20; xx < 24; xx++) pix(xx, yy, 12'h1A7, "scale_block");
        pix(24, 8, 12'h0C3, "scale_next_col");

        // back-buffer isolation at addr 100 (x=400, y=0)
        pal_wr(5, 12'h555);
        pal_wr(9, 12'h9F9);
        do_swap();
        fb_wr(100, 5);
        fb_wr(175, 5);
        do_swap();
        pix(400, 0, 12'h555, "iso_before");
        fb_wr(100, 9);
        fb_wr(175, 5);
        pix(400, 0, 12'h555, "iso_unchanged");
        fb_wr(19200, 1);
        fb_wr(32767, 1);
        do_swap();
        pix(400, 0, 12'h9F9, "iso_after_swap");
        pix(60, 4, 12'h555, "addr175");
        pix(700, 0, 12'h000, "oor_x700");
        pix(0, 480, 12'h000, "oor_y480");

        // swap gating
        f0 = front_m;
        swap_req = 1'b1;
        repeat (1000) @(negedge dclk);
        chk("no_toggle_1000", 12'(front_sel), 12'(f0));
        pre_frame = 1'b1;
        @(negedge dclk);
        pre_frame = 1'b0;
        chk("single_toggle", 12'(front_sel), 12'(!f0));
        acks = 0;
        for (int fr = 0; fr < 3; fr++) begin
            repeat (20) begin
                @(negedge dclk);
                if (swap_ack) acks++;
            end
            pre_frame = 1'b1;
            @(negedge dclk);
            pre_frame = 1'b0;
            if (swap_ack) acks++;
        end
        swap_req = 1'b0;
        @(negedge dclk);
        if (swap_ack) acks++;
        chk("three_acks", 12'(acks), 12'd3);
        chk("three_toggles", 12'(front_sel), 12'(f0));

        // preload random region (fx 40..55, fy 0..7) in both banks
        for (int k = 0; k < 2; k++) begin
            for (int fy = 0; fy < 8; fy++)
                for (int fx = 40; fx < 56; fx++) fb_wr(fy * 160 + fx, $urandom_range(0, 15));
            do_swap();
        end

        // randomised scanout with concurrent writes, palette updates and swaps
        prev_swap = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            x = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(640, 1023)) : 10'($urandom_range(160, 223));
            y = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(480, 1023)) : 10'($urandom_range(0, 31));
            wr_en   = !prev_swap && ($urandom_range(0, 1) == 1);
            wr_addr = ($urandom_range(0, 15) == 0) ? 15'($urandom_range(19200, 32767))
                      : 15'($urandom_range(0, 7) * 160 + $urandom_range(40, 55));
            wr_data = 4'($urandom_range(0, 15));
            pal_we  = ($urandom_range(0, 7) == 0);
            pal_idx = 4'($urandom_range(0, 15));
            pal_rgb = 12'($urandom_range(0, 4095));
            pre_frame = ($urandom_range(0, 49) == 0);
            swap_req  = ($urandom_range(0, 1) == 1);
            prev_swap = pre_frame && swap_req;
            @(negedge dclk);
        end
        wr_en = 1'b0; pal_we = 1'b0; pre_frame = 1'b0; swap_req = 1'b0;
        @(negedge dclk);

        // reset mid-stream
        if (!front_m) do_swap();
        x = 10'd20; y = 10'd8;
        repeat (3) @(negedge dclk);
        #3 clr = 1'b1;
        #1;
        chk("midreset_rgb", {red, green, blue}, 12'h000);
        chk("midreset_front", 12'(front_sel), 12'h000);
        chk("midreset_ack", 12'(swap_ack), 12'h000);
        @(negedge dclk);
        @(negedge dclk);
        clr = 1'b0;
        pal_we = 1'b1; pal_idx = 4'd7; pal_rgb = 12'hABC;
        @(negedge dclk);
        pal_we = 1'b0;
        @(negedge dclk);
        chk("post_reset_pal", {red, green, blue}, 12'hABC);
        repeat (4) @(negedge dclk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
